id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  DLX decode-stage operand fetch; consumes the two register-file read-mux outputs (rs1, rs2 ports).
//  Applies EX/MEM/WB bypassing, detects load-use hazards and latches operands into the ID/EX register.
//  Produces the stall back to IF/ID and a saturating stall-cycle count for performance debug.
// PARAMETERS
//  DATA_W   32   operand / result width
//  REG_AW   5    register index width (32 GPRs, r0 reads as zero)
//  CNT_W    16   width of stall_cnt, saturating
// PORTS
//  clk          in   1       rising-edge clock, single domain
//  rst_n        in   1       synchronous active-low reset
//  id_valid     in   1       instruction in ID is real (not a bubble)
//  id_rs1       in   REG_AW  source 1 index (also drives rs1 read mux select)
//  id_rs2       in   REG_AW  source 2 index
//  id_rs1_used  in   1       instruction reads rs1
//  id_rs2_used  in   1       instruction reads rs2
//  id_rd        in   REG_AW  destination index; 0 = no write
//  rf_data1     in   DATA_W  register-file read data for id_rs1
//  rf_data2     in   DATA_W  register-file read data for id_rs2
//  ex_valid/ex_rd/ex_is_load/ex_result    in 1/REG_AW/1/DATA_W  EX-stage producer
//  mem_valid/mem_rd/mem_result            in 1/REG_AW/DATA_W    MEM-stage producer (load data valid here)
//  wb_valid/wb_rd/wb_result               in 1/REG_AW/DATA_W    WB-stage producer
//  ex_hold      in   1       downstream stall: ID/EX must hold
//  flush        in   1       branch/exception squash of the ID instruction
//  id_stall     out  1       hold PC and IF/ID this cycle (combinational)
//  idex_valid   out  1       ID/EX register valid
//  idex_a       out  DATA_W  ID/EX operand A
//  idex_b       out  DATA_W  ID/EX operand B
//  idex_rd      out  REG_AW  ID/EX destination
//  stall_cnt    out  CNT_W   cycles with id_stall=1, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): idex_valid=0, idex_a=0, idex_b=0, idex_rd=0, stall_cnt=0.
//  - Forward select per operand, priority EX > MEM > WB > rf_data; a stage matches when its valid=1,
//    its rd equals the source index and rd!=0. Source index 0 always yields 0, never forwarded.
//  - EX match with ex_is_load=1 is not forwardable: load_use = id_valid & used & match; no EX forward.
//  - id_stall = load_use | ex_hold (combinational, no latency).
//  - ID/EX update at clk edge, in priority order:
//      flush=1          -> idex_valid<=0 (overrides ex_hold and load_use); data regs hold.
//      ex_hold=1        -> all idex_* hold.
//      load_use=1       -> bubble: idex_valid<=0, idex_rd<=0; data regs hold.
//      otherwise        -> idex_valid<=id_valid, idex_a/b<=forwarded operands, idex_rd<=id_rd.
//  - Latency: operands visible on idex_* one cycle after accepted in ID.
//  - Load-use resolves in exactly one bubble: next cycle the load sits in MEM and forwards mem_result.
//  - stall_cnt increments by 1 each cycle id_stall=1 and rst_n=1; holds at 2^CNT_W-1; never wraps.
//  - Unused source (used=0) never causes load_use; its operand value is don't-care but still muxed.
//  - id_valid=0: no load_use, forwarded values still computed; idex_valid<=0 on load.
//  - Reset mid-stall: reset wins, bubble in ID/EX, stall_cnt cleared.
// STRUCTURE
//  - dlx_pkg: DATA_W, REG_AW, REG_ZERO constant, fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
//  - Sub-module fwd_mux: compare logic + 4:1 select for one operand; instantiated twice (A, B).
//  - Top: hazard detect, ID/EX register, stall counter.
// TESTING
//  1 Reset: rst_n=0 two cycles -> idex_valid=0, idex_a=idex_b=0, stall_cnt=0.
//  2 No hazard: rs1=3 rf_data1=0x11, rs2=4 rf_data2=0x22 -> next cycle idex_a=0x11, idex_b=0x22, idex_valid=1.
//  3 Priority: rs1=5; EX rd=5 res=0xA, MEM rd=5 res=0xB, WB rd=5 res=0xC -> idex_a=0xA; drop EX valid -> 0xB.
//  4 r0: rs1=0, EX rd=0 res=0xDEAD, rf_data1=0x5 -> idex_a=0.
//  5 Load-use: EX load rd=7, ID rs2=7 used -> id_stall=1 one cycle, bubble, stall_cnt=1; next cycle
//    MEM rd=7 res=0x99 -> idex_b=0x99, idex_valid=1.
//  6 flush with ex_hold=1 -> idex_valid=0 next cycle; ex_hold alone holds idex_a for 3 cycles, stall_cnt+=3.

Source files
------------

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared widths and forwarding-select encoding for the DLX decode stage.
package dlx_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: bypass compare and 4:1 operand select for one source register.
module fwd_mux
    import dlx_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] i_src,
    input  logic [DW-1:0] i_rf_data,
    input  logic          i_ex_valid,
    input  logic [AW-1:0] i_ex_rd,
    input  logic          i_ex_is_load,
    input  logic [DW-1:0] i_ex_result,
    input  logic          i_mem_valid,
    input  logic [AW-1:0] i_mem_rd,
    input  logic [DW-1:0] i_mem_result,
    input  logic          i_wb_valid,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [DW-1:0] i_wb_result,
    output logic          o_ex_match,
    output logic [DW-1:0] o_data
);
    logic     w_ex;
    logic     w_mem;
    logic     w_wb;
    fwd_sel_t w_sel;

    assign w_ex  = i_ex_valid  && i_ex_rd  == i_src && i_ex_rd  != '0;
    assign w_mem = i_mem_valid && i_mem_rd == i_src && i_mem_rd != '0;
    assign w_wb  = i_wb_valid  && i_wb_rd  == i_src && i_wb_rd  != '0;
    assign o_ex_match = w_ex;

    // A load in EX has no data yet, so it drops out of the priority chain.
    assign w_sel = (w_ex && !i_ex_is_load) ? FWD_EX :
                   w_mem                   ? FWD_MEM :
                   w_wb                    ? FWD_WB : FWD_RF;

    assign o_data = (i_src == '0)      ? '0 :
                    (w_sel == FWD_EX)  ? i_ex_result :
                    (w_sel == FWD_MEM) ? i_mem_result :
                    (w_sel == FWD_WB)  ? i_wb_result : i_rf_data;
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: DLX ID operand fetch with bypassing, load-use stall and ID/EX register.
module id_operand_stage #(
    parameter int DATA_W = dlx_pkg::DATA_W,
    parameter int REG_AW = dlx_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              id_stall,
    output logic              idex_valid,
    output logic [DATA_W-1:0] idex_a,
    output logic [DATA_W-1:0] idex_b,
    output logic [REG_AW-1:0] idex_rd,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              w_a_ex;
    logic              w_b_ex;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_load_use;
    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [REG_AW-1:0] r_rd;
    logic [CNT_W-1:0]  r_cnt;

    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_a (
        .i_src(id_rs1), .i_rf_data(rf_data1),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load), .i_ex_result(ex_result),
        .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_result(wb_result),
        .o_ex_match(w_a_ex), .o_data(w_a)
    );

    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_b (
        .i_src(id_rs2), .i_rf_data(rf_data2),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load), .i_ex_result(ex_result),
        .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_result(wb_result),
        .o_ex_match(w_b_ex), .o_data(w_b)
    );

    assign w_load_use = id_valid && ex_is_load && ((id_rs1_used && w_a_ex) || (id_rs2_used && w_b_ex));
    assign id_stall   = w_load_use || ex_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (ex_hold) begin
                r_valid <= r_valid;
            end else if (w_load_use) begin
                r_valid <= 1'b0;
                r_rd    <= '0;
            end else begin
                r_valid <= id_valid;
                r_a     <= w_a;
                r_b     <= w_b;
                r_rd    <= id_rd;
            end
            if (id_stall && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign idex_valid = r_valid;
    assign idex_a     = r_a;
    assign idex_b     = r_b;
    assign idex_rd    = r_rd;
    assign stall_cnt  = r_cnt;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed + random stimulus against a queue-based scoreboard and reference model.
module tb_id_operand_stage;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
    logic [31:0] rf_data1, rf_data2, ex_result, mem_result, wb_result;
    logic        ex_valid, ex_is_load, mem_valid, wb_valid, ex_hold, flush;
    logic        id_stall, idex_valid;
    logic [31:0] idex_a, idex_b;
    logic [4:0]  idex_rd;
    logic [CW-1:0] stall_cnt;

    id_operand_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall), .idex_valid(idex_valid),
        .idex_a(idex_a), .idex_b(idex_b), .idex_rd(idex_rd), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int due; logic s;} stall_exp_t;
    typedef struct {int due; logic v; logic [31:0] a; logic [31:0] b; logic [4:0] rd; int cnt;} state_exp_t;

    stall_exp_t q_stall[$];
    state_exp_t q_state[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic        m_v = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [4:0]  m_rd = '0;
    int          m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares whatever expectations fall due at this cycle.
    always @(negedge clk) begin
        stall_exp_t se;
        state_exp_t te;
        while (q_stall.size() > 0 && q_stall[0].due == cyc) begin
            se = q_stall.pop_front();
            chk("id_stall", {31'b0, id_stall}, {31'b0, se.s});
        end
        while (q_state.size() > 0 && q_state[0].due == cyc) begin
            te = q_state.pop_front();
            chk("idex_valid", {31'b0, idex_valid}, {31'b0, te.v});
            chk("idex_a", idex_a, te.a);
            chk("idex_b", idex_b, te.b);
            chk("idex_rd", {27'b0, idex_rd}, {27'b0, te.rd});
            chk("stall_cnt", {28'b0, stall_cnt}, te.cnt[31:0]);
        end
    end

    // Reference: newest non-load producer naming the source wins; r0 is hardwired zero.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        logic        sv[3];
        logic [4:0]  sr[3];
        logic [31:0] sd[3];
        sv = '{ex_valid && !ex_is_load, mem_valid, wb_valid};
        sr = '{ex_rd, mem_rd, wb_rd};
        sd = '{ex_result, mem_result, wb_result};
        if (src == 0) return 32'h0;
        for (int i = 0; i < 3; i++)
            if (sv[i] && sr[i] == src) return sd[i];
        return rf;
    endfunction

    task automatic step();
        logic lu, st;
        logic [31:0] fa, fb;
        fa = fwd(id_rs1, rf_data1);
        fb = fwd(id_rs2, rf_data2);
        lu = id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
             ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2));
        st = lu || ex_hold;
        q_stall.push_back('{cyc, st});
        if (!rst_n) begin
            m_v = 0; m_a = 0; m_b = 0; m_rd = 0; m_cnt = 0;
        end else begin
            if (flush) m_v = 0;
            else if (ex_hold) m_v = m_v;
            else if (lu) begin m_v = 0; m_rd = 0; end
            else begin m_v = id_valid; m_a = fa; m_b = fb; m_rd = id_rd; end
            if (st && m_cnt < CMAX) m_cnt++;
        end
        q_state.push_back('{cyc + 1, m_v, m_a, m_b, m_rd, m_cnt});
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        rst_n = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd = 0;
        rf_data1 = 0; rf_data2 = 0; ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0;
        mem_valid = 0; mem_rd = 0; mem_result = 0; wb_valid = 0; wb_rd = 0; wb_result = 0;
        ex_hold = 0; flush = 0;
    endtask

    task automatic rand_step();
        rst_n = ($urandom_range(0, 49) != 0);
        id_valid = ($urandom_range(0, 4) != 0);
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
        id_rs1_used = $urandom_range(0, 3) != 0; id_rs2_used = $urandom_range(0, 3) != 0;
        rf_data1 = $urandom; rf_data2 = $urandom;
        ex_valid = $urandom_range(0, 1) == 1; ex_rd = 5'($urandom_range(0, 7));
        ex_is_load = $urandom_range(0, 3) == 0; ex_result = $urandom;
        mem_valid = $urandom_range(0, 1) == 1; mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
        wb_valid = $urandom_range(0, 1) == 1; wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
        ex_hold = $urandom_range(0, 6) == 0; flush = $urandom_range(0, 9) == 0;
        step();
    endtask

    initial begin
        quiet();
        rst_n = 0;
        @(posedge clk);
        #2;
        step();
        step();
        rst_n = 1;
        id_valid = 1; id_rs1_used = 1; id_rs2_used = 1; id_rd = 1;
        id_rs1 = 3; rf_data1 = 32'h11; id_rs2 = 4; rf_data2 = 32'h22;
        step();
        id_rs1 = 5; ex_valid = 1; ex_rd = 5; ex_result = 32'hA;
        mem_valid = 1; mem_rd = 5; mem_result = 32'hB; wb_valid = 1; wb_rd = 5; wb_result = 32'hC;
        step();
        ex_valid = 0;
        step();
        mem_valid = 0;
        step();
        id_rs1 = 0; ex_valid = 1; ex_rd = 0; ex_result = 32'hDEAD; rf_data1 = 32'h5;
        step();
        quiet();
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; id_rd = 2; rf_data2 = 32'h1234;
        ex_valid = 1; ex_rd = 7; ex_is_load = 1;
        step();
        ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd = 7; mem_result = 32'h99;
        step();
        quiet();
        id_valid = 1; id_rd = 3; id_rs1 = 9; id_rs1_used = 1; rf_data1 = 32'h77;
        step();
        flush = 1; ex_hold = 1; rf_data1 = 32'h88;
        step();
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            rf_data1 = $urandom;
            step();
        end
        ex_hold = 0;
        step();
        ex_hold = 1;
        for (int i = 0; i < CMAX + 2; i++) step();
        rst_n = 0;
        step();
        quiet();
        step();
        for (int i = 0; i < 400; i++) rand_step();
        quiet();
        step();
        repeat (3) @(posedge clk);
        #1;
        if (q_stall.size() != 0 || q_state.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", q_stall.size() + q_state.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
